// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//   Constants and types shared by the timer's counter-control stage and the
//   APB register block.
//   - TMR_DIV_W / TMR_MAX_DIV / TMR_PRESC_W : default prescaler geometry.
//   - TCR_*                                 : TCR field bit positions.
//   - tcr_cfg_t                             : prescaler config snapshot
//                                             (div_en + div_val).
// ---------------------------------------------------------------------------
package timer_pkg;

    // Prescaler geometry. TMR_PRESC_W must be >= TMR_MAX_DIV so that
    // 2^MAX_DIV - 1 fits in the prescaler counter.
    localparam int TMR_DIV_W   = 4;
    localparam int TMR_MAX_DIV = 8;
    localparam int TMR_PRESC_W = 8;

    // TCR field positions, shared with the register block.
    localparam int TCR_TIMER_EN_BIT = 0;
    localparam int TCR_DIV_EN_BIT   = 1;
    localparam int TCR_DIV_VAL_LSB  = 4;
    localparam int TCR_DIV_VAL_MSB  = TCR_DIV_VAL_LSB + TMR_DIV_W - 1;

    // Registered copy of the prescaler configuration, used to detect
    // configuration writes while the timer is running.
    typedef struct packed {
        logic                 div_en;
        logic [TMR_DIV_W-1:0] div_val;
    } tcr_cfg_t;

endpackage : timer_pkg

// File: rtl/cnt_ctrl_if.sv
// ---------------------------------------------------------------------------
// cnt_ctrl_if
//   Bundle between the register block / counter and the counter-control
//   stage.
//   Register-block -> cnt_ctrl : timer_en, div_en, div_val, dbg_mode, halt_req
//   cnt_ctrl -> counter        : cnt_en (1-cycle count strobe), halt_en
//   cnt_ctrl -> register block : halt_ack (registered)
//
//   Handshake: halt is a level handshake, not valid/ready. The requester
//   holds halt_req high for as long as it wants the counter frozen;
//   halt_ack follows the effective halt (dbg_mode & halt_req) with exactly
//   one cycle of latency on both assertion and deassertion.
//
//   master : register-block side (drives config, receives status)
//   slave  : cnt_ctrl side
// ---------------------------------------------------------------------------
interface cnt_ctrl_if;
    import timer_pkg::*;

    logic                 timer_en;
    logic                 div_en;
    logic [TMR_DIV_W-1:0] div_val;
    logic                 dbg_mode;
    logic                 halt_req;
    logic                 cnt_en;
    logic                 halt_en;
    logic                 halt_ack;

    modport master (
        output timer_en, div_en, div_val, dbg_mode, halt_req,
        input  cnt_en, halt_en, halt_ack
    );

    modport slave (
        input  timer_en, div_en, div_val, dbg_mode, halt_req,
        output cnt_en, halt_en, halt_ack
    );

endinterface : cnt_ctrl_if

// File: rtl/cnt_ctrl.sv
// ---------------------------------------------------------------------------
// cnt_ctrl
//   Counter-control stage in front of the 64-bit timer counter. Produces the
//   per-cycle count strobe from timer enable and a power-of-two prescaler
//   (ratio 2^min(div_val, MAX_DIV)), and the counter freeze from the debug
//   halt handshake.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : cnt_ctrl_if.slave
//              in : timer_en, div_en, div_val, dbg_mode, halt_req
//              out: cnt_en   - combinational count strobe
//                   halt_en  - combinational counter freeze
//                   halt_ack - registered copy of halt_en
//
//   The DIV_W parameter must match the interface's div_val width
//   (timer_pkg::TMR_DIV_W).
// ---------------------------------------------------------------------------
module cnt_ctrl
    import timer_pkg::*;
#(
    parameter int PRESC_W = TMR_PRESC_W,
    parameter int DIV_W   = TMR_DIV_W,
    parameter int MAX_DIV = TMR_MAX_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    cnt_ctrl_if.slave   bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] int_cnt_q, int_cnt_d;
    tcr_cfg_t           cfg_q,     cfg_d;
    logic               halt_ack_q, halt_ack_d;

    // ------------------------------------------------------------------
    // Derived prescaler controls
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]   k;
    logic [PRESC_W:0]   pow2;
    logic [PRESC_W-1:0] limit;
    logic               bypass;
    logic               cfg_chg;
    logic               halt_en;
    logic               at_limit;

    always_comb begin
        // Exponents above MAX_DIV behave as MAX_DIV.
        k = bus.div_val;
        if (bus.div_val > DIV_W'(MAX_DIV)) begin
            k = DIV_W'(MAX_DIV);
        end

        // One extra bit so 2^PRESC_W is representable; dropping the top bit
        // before subtracting still yields the all-ones limit for k==PRESC_W.
        pow2  = (PRESC_W + 1)'(1) << k;
        limit = pow2[PRESC_W-1:0] - PRESC_W'(1);

        bypass   = !bus.div_en || (k == '0);
        at_limit = (int_cnt_q == limit);

        // Compared on raw div_val, so a change between two clamped values
        // still restarts the prescaler.
        cfg_chg = (bus.div_en != cfg_q.div_en) || (bus.div_val != cfg_q.div_val);

        // halt_req outside debug mode is ignored.
        halt_en = bus.dbg_mode && bus.halt_req;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        int_cnt_d      = int_cnt_q;
        cfg_d.div_en   = bus.div_en;
        cfg_d.div_val  = bus.div_val;
        halt_ack_d     = halt_en;

        // Priority order matters: a config change clears even while halted,
        // and a halt preserves the prescaler phase across the freeze.
        if (!bus.timer_en) begin
            int_cnt_d = '0;
        end else if (cfg_chg) begin
            int_cnt_d = '0;
        end else if (halt_en) begin
            int_cnt_d = int_cnt_q;
        end else if (bypass) begin
            int_cnt_d = '0;
        end else if (at_limit) begin
            int_cnt_d = '0;
        end else begin
            int_cnt_d = int_cnt_q + PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_cnt_q  <= '0;
            cfg_q      <= '0;
            halt_ack_q <= 1'b0;
        end else begin
            int_cnt_q  <= int_cnt_d;
            cfg_q      <= cfg_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cnt_en   = bus.timer_en && !halt_en && !cfg_chg && (bypass || at_limit);
    assign bus.halt_en  = halt_en;
    assign bus.halt_ack = halt_ack_q;

endmodule : cnt_ctrl

// File: tb/tb_cnt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cnt_ctrl
//   Directed bench for cnt_ctrl. Inputs change 1 time unit after the rising
//   edge; outputs are sampled on the falling edge. "Cycle c" is the clock
//   period in which the inputs for step c are applied.
// ---------------------------------------------------------------------------
module tb_cnt_ctrl;
    import timer_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    cnt_ctrl_if bus ();

    cnt_ctrl #(
        .PRESC_W (TMR_PRESC_W),
        .DIV_W   (TMR_DIV_W),
        .MAX_DIV (TMR_MAX_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks;
    int errors;

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drop timer_en for a couple of cycles and load a new divider so that
    // the next test starts from a cleared prescaler with settled config.
    task automatic reconfigure(input logic den, input logic [TMR_DIV_W-1:0] dval);
        bus.timer_en = 1'b0;
        bus.halt_req = 1'b0;
        bus.div_en   = den;
        bus.div_val  = dval;
        idle_cycles(2);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n        = 1'b0;
        bus.timer_en = 1'b0;
        bus.div_en   = 1'b0;
        bus.div_val  = '0;
        bus.dbg_mode = 1'b0;
        bus.halt_req = 1'b0;
        idle_cycles(3);
        @(negedge clk);
        checks++;
        if (bus.cnt_en !== 1'b0) begin
            errors++; $display("FAIL reset_cnt_en got %b exp 0", bus.cnt_en);
        end
        checks++;
        if (bus.halt_en !== 1'b0) begin
            errors++; $display("FAIL reset_halt_en got %b exp 0", bus.halt_en);
        end
        checks++;
        if (bus.halt_ack !== 1'b0) begin
            errors++; $display("FAIL reset_halt_ack got %b exp 0", bus.halt_ack);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        bus.timer_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (bus.cnt_en !== 1'b1) begin
                errors++; $display("FAIL bypass_cnt_en c=%0d got %b exp 1", c, bus.cnt_en);
            end
            checks++;
            if (bus.halt_ack !== 1'b0) begin
                errors++; $display("FAIL bypass_halt_ack c=%0d got %b exp 0", c, bus.halt_ack);
            end
            tick();
        end
        bus.timer_en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cnt_en !== 1'b0) begin
            errors++; $display("FAIL bypass_disabled got %b exp 0", bus.cnt_en);
        end
        tick();
    endtask

    task automatic test_div4();
        int   strobes;
        logic exp;
        strobes = 0;
        reconfigure(1'b1, 4'd2);
        for (int c = 0; c <= 12; c++) begin
            if (c == 0) bus.timer_en = 1'b1;
            @(negedge clk);
            exp = (c == 3 || c == 7 || c == 11);
            checks++;
            if (bus.cnt_en !== exp) begin
                errors++; $display("FAIL div4_cnt_en c=%0d got %b exp %b", c, bus.cnt_en, exp);
            end
            if (bus.cnt_en === 1'b1) strobes++;
            tick();
        end
        checks++;
        if (strobes != 3) begin
            errors++; $display("FAIL div4_counter got %0d exp 3", strobes);
        end
    endtask

    task automatic test_halt();
        logic exp_cnt, exp_halt, exp_ack;
        reconfigure(1'b1, 4'd3);
        bus.dbg_mode = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            if (c == 0) bus.timer_en = 1'b1;
            if (c == 4) bus.halt_req = 1'b1;
            if (c == 9) bus.halt_req = 1'b0;
            @(negedge clk);
            exp_cnt  = (c == 12);
            exp_halt = (c >= 4 && c <= 8);
            exp_ack  = (c >= 5 && c <= 9);
            checks++;
            if (bus.cnt_en !== exp_cnt) begin
                errors++; $display("FAIL halt_cnt_en c=%0d got %b exp %b", c, bus.cnt_en, exp_cnt);
            end
            checks++;
            if (bus.halt_en !== exp_halt) begin
                errors++; $display("FAIL halt_halt_en c=%0d got %b exp %b", c, bus.halt_en, exp_halt);
            end
            checks++;
            if (bus.halt_ack !== exp_ack) begin
                errors++; $display("FAIL halt_ack c=%0d got %b exp %b", c, bus.halt_ack, exp_ack);
            end
            tick();
        end
        bus.dbg_mode = 1'b0;
    endtask

    task automatic test_halt_no_dbg();
        logic exp_cnt;
        reconfigure(1'b1, 4'd3);
        bus.dbg_mode = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            if (c == 0) begin
                bus.timer_en = 1'b1;
                bus.halt_req = 1'b1;
            end
            @(negedge clk);
            exp_cnt = (c == 7 || c == 15);
            checks++;
            if (bus.cnt_en !== exp_cnt) begin
                errors++; $display("FAIL nodbg_cnt_en c=%0d got %b exp %b", c, bus.cnt_en, exp_cnt);
            end
            checks++;
            if (bus.halt_en !== 1'b0 || bus.halt_ack !== 1'b0) begin
                errors++;
                $display("FAIL nodbg_halt c=%0d got en=%b ack=%b exp 0/0", c, bus.halt_en, bus.halt_ack);
            end
            tick();
        end
        bus.halt_req = 1'b0;
    endtask

    task automatic test_cfg_change();
        logic exp_cnt;
        reconfigure(1'b1, 4'd4);
        for (int c = 0; c <= 16; c++) begin
            if (c == 0)  bus.timer_en = 1'b1;
            if (c == 10) bus.div_val  = 4'd1;
            @(negedge clk);
            exp_cnt = (c == 12 || c == 14 || c == 16);
            checks++;
            if (bus.cnt_en !== exp_cnt) begin
                errors++; $display("FAIL cfgchg_cnt_en c=%0d got %b exp %b", c, bus.cnt_en, exp_cnt);
            end
            tick();
        end
    endtask

    // Halt and a config write in the same cycle: the write clears the
    // prescaler, the halt does not preserve the old phase.
    task automatic test_halt_and_cfg();
        logic exp_cnt;
        reconfigure(1'b1, 4'd2);
        bus.dbg_mode = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c == 0) bus.timer_en = 1'b1;
            if (c == 2) begin
                bus.halt_req = 1'b1;
                bus.div_val  = 4'd1;
            end
            if (c == 3) bus.halt_req = 1'b0;
            @(negedge clk);
            exp_cnt = (c == 4 || c == 6);
            checks++;
            if (bus.cnt_en !== exp_cnt) begin
                errors++; $display("FAIL haltcfg_cnt_en c=%0d got %b exp %b", c, bus.cnt_en, exp_cnt);
            end
            tick();
        end
        bus.dbg_mode = 1'b0;
    endtask

    // div_val 15 clamps to 256; timer_en drop clears phase; a write between
    // two clamped values still restarts the prescaler.
    task automatic test_clamp();
        logic exp_cnt;
        int   bad;
        reconfigure(1'b1, 4'd15);
        bad = 0;
        for (int c = 0; c <= 600; c++) begin
            if (c == 0) bus.timer_en = 1'b1;
            @(negedge clk);
            exp_cnt = (c == 255 || c == 511);
            checks++;
            if (bus.cnt_en !== exp_cnt) begin
                errors++;
                if (bad < 5) $display("FAIL clamp_cnt_en c=%0d got %b exp %b", c, bus.cnt_en, exp_cnt);
                bad++;
            end
            tick();
        end
        bus.timer_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.cnt_en !== 1'b0) begin
                errors++; $display("FAIL clamp_off_cnt_en c=%0d got %b exp 0", c, bus.cnt_en);
            end
            tick();
        end
        for (int c = 0; c <= 520; c++) begin
            if (c == 0)   bus.timer_en = 1'b1;
            if (c == 260) bus.div_val  = 4'd12;
            @(negedge clk);
            exp_cnt = (c == 255 || c == 516);
            checks++;
            if (bus.cnt_en !== exp_cnt) begin
                errors++;
                if (bad < 10) $display("FAIL clamp_reen_cnt_en c=%0d got %b exp %b", c, bus.cnt_en, exp_cnt);
                bad++;
            end
            tick();
        end
        bus.timer_en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        reconfigure(1'b0, 4'd0);
        bus.dbg_mode = 1'b1;
        bus.halt_req = 1'b1;
        idle_cycles(2);
        @(negedge clk);
        checks++;
        if (bus.halt_ack !== 1'b1) begin
            errors++; $display("FAIL arst_pre_ack got %b exp 1", bus.halt_ack);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.halt_ack !== 1'b0) begin
            errors++; $display("FAIL arst_ack got %b exp 0", bus.halt_ack);
        end
        bus.dbg_mode = 1'b0;
        bus.halt_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.halt_ack !== 1'b0 || bus.cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL arst_after got ack=%b cnt_en=%b exp 0/0", bus.halt_ack, bus.cnt_en);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_bypass();
        test_div4();
        test_halt();
        test_halt_no_dbg();
        test_cfg_change();
        test_halt_and_cfg();
        test_clamp();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cnt_ctrl
